// File: rtl/icc_pkg.sv
// Shared definitions for the inter-core mailbox arbiter: word width, head FSM
// states, cons_status field positions and a constant clog2 helper.
package icc_pkg;

    localparam int ICC_WORD_W = 14;

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PRESENT = 2'd1,
        S_POP     = 2'd2
    } icc_state_e;

    // cons_status layout: [0] valid, [3:1] source id, [7:4] count, rest zero
    localparam int ST_VALID_BIT = 0;
    localparam int ST_SRC_LSB   = 1;
    localparam int ST_SRC_W     = 3;
    localparam int ST_CNT_LSB   = 4;
    localparam int ST_CNT_W     = 4;

    function automatic int icc_clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/icc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among NUM_REQ requesters, searching from
// the requester after the last winner. Holds the last_grant register.
module icc_rr_arbiter
    import icc_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    localparam int ID_W    = (NUM_REQ > 1) ? icc_clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_any
);

    logic [ID_W-1:0] last_grant;

    // Pick the first valid requester starting at last_grant+1, wrapping around
    always_comb begin : grant_search
        int k;
        // NOTE: every output gets a default before any branch so no latch is inferred.
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        k         = 0;
        if (enable) begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                k = (int'(last_grant) + i) % NUM_REQ;
                if (!grant_any && req_valid[k[ID_W-1:0]]) begin
                    grant[k[ID_W-1:0]] = 1'b1;
                    grant_id           = k[ID_W-1:0];
                    grant_any          = 1'b1;
                end
            end
        end
    end

    // Remember the winner; reset so requester 0 has priority first
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so all flops update together.
        if (rst) begin
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (grant_any) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/icc_mailbox_arbiter.sv
// Mailbox arbiter between NUM_REQ worker cores and core0. Worker words are
// granted round-robin into a FIFO; the head is shown to core0 as cons_data plus
// cons_status, and core0 pops it by toggling cons_ack[0].
// Optional feature: define ICC_TIMESTAMP_EN to record a 14-bit cycle stamp
// with each entry and present it on cons_stamp (otherwise cons_stamp is 0).
module icc_mailbox_arbiter
    import icc_pkg::*;
#(
    parameter int WORD_W  = ICC_WORD_W,
    parameter int NUM_REQ = 3,
    parameter int DEPTH   = 8
) (
    input  logic                      Clock_pin,
    input  logic                      Reset_pin,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*WORD_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [WORD_W-1:0]         cons_data,
    output logic [WORD_W-1:0]         cons_status,
    input  logic [WORD_W-1:0]         cons_ack,
    output logic [WORD_W-1:0]         cons_stamp
);

    localparam int PTR_W = icc_clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ID_W  = (NUM_REQ > 1) ? icc_clog2(NUM_REQ) : 1;

    logic [WORD_W-1:0]   mem_data [DEPTH];
    logic [ST_SRC_W-1:0] mem_src  [DEPTH];

    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;

    icc_state_e          state;
    logic                valid_r;
    logic [ST_SRC_W-1:0] head_src;
    logic                ack_prev;

    logic                grant_enable;
    logic                grant_any;
    logic [ID_W-1:0]     grant_id;
    logic [WORD_W-1:0]   push_word;
    logic                tog;
    logic                pop;
    logic                head_load;

    // Only bit0 of the ack port carries meaning
    logic unused_ack;
    assign unused_ack = ^cons_ack[WORD_W-1:1];

    // Grants need free space (registered count, so a same-cycle pop does not
    // help) and are suppressed while reset is asserted
    assign grant_enable = !Reset_pin && (count < CNT_W'(DEPTH));

    icc_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk       (Clock_pin),
        .rst       (Reset_pin),
        .req_valid (req_valid),
        .enable    (grant_enable),
        .grant     (req_ready),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    assign tog       = cons_ack[0] ^ ack_prev;
    assign pop       = (state == S_PRESENT) && tog;
    assign head_load = ((state == S_EMPTY) || (state == S_POP)) && (count != '0);

    // Select the granted worker's word slice
    always_comb begin
        push_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                push_word = req_data[i*WORD_W +: WORD_W];
            end
        end
    end

`ifdef ICC_TIMESTAMP_EN
    logic [ICC_WORD_W-1:0] ts_cnt;
    logic [ICC_WORD_W-1:0] mem_stamp [DEPTH];
    logic [ICC_WORD_W-1:0] stamp_r;

    // Free-running cycle counter, wraps naturally at 2^14
    always_ff @(posedge Clock_pin) begin
        if (Reset_pin) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + ICC_WORD_W'(1);
        end
    end

    // Stamp storage written alongside the word
    always_ff @(posedge Clock_pin) begin
        if (grant_any) begin
            mem_stamp[wr_ptr] <= ts_cnt;
        end
    end

    // Head stamp loads together with cons_data
    always_ff @(posedge Clock_pin) begin
        if (Reset_pin) begin
            stamp_r <= '0;
        end else if (head_load) begin
            stamp_r <= mem_stamp[rd_ptr];
        end
    end

    assign cons_stamp = WORD_W'(stamp_r);
`else
    assign cons_stamp = '0;
`endif

    // FIFO storage write on an accepted word
    always_ff @(posedge Clock_pin) begin
        // NOTE: storage is deliberately not reset; pointers and count define which entries are live.
        if (grant_any) begin
            mem_data[wr_ptr] <= push_word;
            mem_src[wr_ptr]  <= ST_SRC_W'(grant_id);
        end
    end

    // Write pointer and occupancy; push and pop together leave count unchanged
    always_ff @(posedge Clock_pin) begin
        if (Reset_pin) begin
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (grant_any) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            case ({grant_any, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head presentation FSM with registered valid, data and source id
    always_ff @(posedge Clock_pin) begin
        if (Reset_pin) begin
            state     <= S_EMPTY;
            valid_r   <= 1'b0;
            cons_data <= '0;
            head_src  <= '0;
            rd_ptr    <= '0;
            ack_prev  <= 1'b0;
        end else begin
            ack_prev <= cons_ack[0];
            case (state)
                S_EMPTY: begin
                    if (head_load) begin
                        state     <= S_PRESENT;
                        valid_r   <= 1'b1;
                        cons_data <= mem_data[rd_ptr];
                        head_src  <= mem_src[rd_ptr];
                    end
                end
                S_PRESENT: begin
                    if (tog) begin
                        state   <= S_POP;
                        valid_r <= 1'b0;
                        rd_ptr  <= rd_ptr + PTR_W'(1);
                    end
                end
                S_POP: begin
                    if (head_load) begin
                        state     <= S_PRESENT;
                        valid_r   <= 1'b1;
                        cons_data <= mem_data[rd_ptr];
                        head_src  <= mem_src[rd_ptr];
                    end else begin
                        state <= S_EMPTY;
                    end
                end
                default: begin
                    state   <= S_EMPTY;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Pack the status word; count is live in every state
    always_comb begin
        cons_status                            = '0;
        cons_status[ST_VALID_BIT]              = valid_r;
        cons_status[ST_SRC_LSB +: ST_SRC_W]    = head_src;
        cons_status[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(count);
    end

endmodule
